// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default widths for the data memory arbiter.
package data_mem_arbiter_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned STAT_W   = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CPU_RD_WAIT  = 2'd1,
        HOST_RD_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// CPU, host and memory-side signals of the data memory arbiter.
interface data_mem_arbiter_if;
    import data_mem_arbiter_pkg::*;

    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory model view
    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; holds at LIMIT.
module data_mem_arbiter_starve_counter #(
    parameter int unsigned W     = 4,
    parameter int unsigned LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU priority with a host starvation guard.
// Optional build macro ARB_STATS_EN adds stall-cycle and host-grant counters.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_stall_cycles,
    output logic [STAT_W-1:0]   stat_host_grants
`endif
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   cpu_rdata_d;
    logic [DATA_W-1:0]   host_rdata_q;
    logic [DATA_W-1:0]   host_rdata_d;
    logic [STARVE_W-1:0] starve_cnt;

    logic                cpu_req_c;
    logic                starve_full_c;
    logic                host_win_c;
    mem_req_t            mem_req_c;
    logic                mem_en_c;
    logic                host_gnt_c;
    logic                host_rvalid_c;
    logic                cpu_stall_c;
    logic [DATA_W-1:0]   cpu_rdata_c;
    logic [DATA_W-1:0]   host_rdata_c;

    assign cpu_req_c     = bus.cpu_read | bus.cpu_write;
    assign starve_full_c = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign host_win_c    = bus.host_req & (~cpu_req_c | starve_full_c);

    // Arbitration and port muxing; rst_n gating keeps every strobe low while reset is held
    always_comb begin
        state_d       = state_q;
        cpu_rdata_d   = cpu_rdata_q;
        host_rdata_d  = host_rdata_q;
        mem_req_c     = '0;
        mem_en_c      = 1'b0;
        host_gnt_c    = 1'b0;
        host_rvalid_c = 1'b0;
        cpu_stall_c   = 1'b0;
        cpu_rdata_c   = cpu_rdata_q;
        host_rdata_c  = host_rdata_q;

        case (state_q)
            IDLE: begin
                if (rst_n && host_win_c) begin
                    mem_en_c    = 1'b1;
                    mem_req_c   = '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};
                    host_gnt_c  = 1'b1;
                    cpu_stall_c = cpu_req_c;
                    if (!bus.host_we) begin
                        state_d = HOST_RD_WAIT;
                    end
                end else if (rst_n && cpu_req_c) begin
                    mem_en_c  = 1'b1;
                    mem_req_c = '{we: bus.cpu_write, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
                    // A store wins over a simultaneous load, so only a pure load waits
                    if (!bus.cpu_write) begin
                        cpu_stall_c = 1'b1;
                        state_d     = CPU_RD_WAIT;
                    end
                end
            end
            CPU_RD_WAIT: begin
                cpu_rdata_c = bus.mem_rdata;
                cpu_rdata_d = bus.mem_rdata;
                state_d     = IDLE;
            end
            HOST_RD_WAIT: begin
                host_rvalid_c = 1'b1;
                host_rdata_c  = bus.mem_rdata;
                host_rdata_d  = bus.mem_rdata;
                cpu_stall_c   = cpu_req_c;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    data_mem_arbiter_starve_counter #(
        .W     (STARVE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.host_req & ~host_gnt_c),
        .clr   (~bus.host_req | host_gnt_c),
        .cnt   (starve_cnt)
    );

    assign bus.mem_en      = mem_en_c;
    assign bus.mem_we      = mem_req_c.we;
    assign bus.mem_addr    = mem_req_c.addr;
    assign bus.mem_wdata   = mem_req_c.wdata;
    assign bus.cpu_stall   = cpu_stall_c;
    assign bus.cpu_rdata   = cpu_rdata_c;
    assign bus.host_gnt    = host_gnt_c;
    assign bus.host_rvalid = host_rvalid_c;
    assign bus.host_rdata  = host_rdata_c;

`ifdef ARB_STATS_EN
    data_mem_arbiter_starve_counter #(
        .W     (STAT_W),
        .LIMIT (32'h0000_FFFF)
    ) u_stat_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cpu_stall_c),
        .clr   (1'b0),
        .cnt   (stat_stall_cycles)
    );

    data_mem_arbiter_starve_counter #(
        .W     (STAT_W),
        .LIMIT (32'h0000_FFFF)
    ) u_stat_gnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (host_gnt_c),
        .clr   (1'b0),
        .cnt   (stat_host_grants)
    );
`endif

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous data memory (8-bit address, 16-bit data) between two requesters.
- Requester 1 is the pipeline memory stage, driven from the execution-stage register outputs (data_read/data_write/addr/data_val).
- Requester 2 is a host/loader port with a req/gnt handshake.
- CPU has priority, with a starvation guard for the host; the block stalls the pipeline whenever the CPU cannot be served in the current cycle.

Parameters:
- DATA_W, 16, memory data width
- ADDR_W, 8, memory address width
- STARVE_LIMIT, 4, consecutive cycles the host may lose arbitration before it is forced to win (range 1..15)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- cpu_read  in  1  pipeline load request, held until stall releases
- cpu_write  in  1  pipeline store request
- cpu_addr  in  ADDR_W  pipeline address
- cpu_wdata  in  DATA_W  pipeline store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_stall low in a CPU_RD_WAIT cycle
- cpu_stall  out  1  freeze pipeline
- host_req  in  1  host request, held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  one-cycle pulse: request issued this cycle
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- host_rdata  out  DATA_W  host read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

Behaviour:
- States: IDLE, CPU_RD_WAIT, HOST_RD_WAIT.
- Reset: state = IDLE, starve_cnt = 0, cpu_rdata_q = 0.
  - Outputs at reset: mem_en = 0, mem_we = 0, host_gnt = 0, host_rvalid = 0, cpu_stall = 0, host_rdata = 0, cpu_rdata = 0.
  - Reset mid-read discards the access; no rvalid and no data pulse follow.
- IDLE arbitration, combinational, decided the same cycle:
  - cpu_req = cpu_read | cpu_write.
  - Host wins if host_req & (!cpu_req | starve_cnt == STARVE_LIMIT); otherwise the CPU wins if cpu_req.
- CPU win:
  - mem_en = 1, mem_we = cpu_write, mem_addr/mem_wdata from the cpu_* inputs.
  - If cpu_read and cpu_write are both high, the write wins and no read wait follows.
  - Write completes in 1 cycle, cpu_stall = 0.
  - Read: cpu_stall = 1 in the issue cycle, next state CPU_RD_WAIT.
- Host win:
  - mem_* driven from the host_* inputs, host_gnt = 1.
  - cpu_stall = cpu_req.
  - Read: next state HOST_RD_WAIT. Write: stay in IDLE.
- CPU_RD_WAIT:
  - mem_en = 0, cpu_rdata = mem_rdata (combinational), cpu_stall = 0.
  - cpu_* inputs are ignored; this is the same held request.
  - Host waits. Next state IDLE.
- HOST_RD_WAIT:
  - mem_en = 0, host_rvalid = 1, host_rdata = mem_rdata, registered into host_rdata hold.
  - cpu_stall = cpu_req. Next state IDLE.
- cpu_rdata outside CPU_RD_WAIT holds the last loaded value.
- starve_cnt, updated at the clock edge:
  - Increments (saturating at STARVE_LIMIT) when host_req is high and the host is not granted.
  - Clears on host grant or when host_req is low.
- No new access is issued in either RD_WAIT state; the port carries at most one read in flight.
- Latency:
  - CPU load: 1 stall cycle.
  - CPU store: 0 stall cycles.
  - Host: grant is in the first IDLE cycle it wins; read data arrives one cycle after grant.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles[15:0] (counts cycles with cpu_stall high) and stat_host_grants[15:0] (counts host_gnt pulses).
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: no counters and no stat ports exist.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, CPU_RD_WAIT = 2'd1, HOST_RD_WAIT = 2'd2), DATA_W/ADDR_W defaults.
- Optional sub-module starve_counter: saturating counter with clear and limit compare, reused by the stats counters.

Test Plan:
- CPU store only: cpu_write = 1, addr = 0x10, data = 0xBEEF → same cycle mem_en = 1, mem_we = 1, mem_addr = 0x10, cpu_stall = 0.
- CPU load of 0xBEEF from 0x10 → cpu_stall = 1 for exactly 1 cycle; next cycle cpu_rdata = 0xBEEF, cpu_stall = 0.
- Continuous CPU stores plus host_req held with STARVE_LIMIT = 4 → CPU wins 4 cycles, host_gnt pulses on cycle 5 with cpu_stall = 1 that cycle, starve_cnt returns to 0.
- Host read of 0x20 (holds 0x1234) while the CPU is idle → host_gnt at cycle 0, host_rvalid = 1 with host_rdata = 0x1234 at cycle 1, no mem_en at cycle 1.
- CPU load issued, RST_N pulsed low during CPU_RD_WAIT → all outputs 0 immediately, state IDLE; no stale cpu_rdata or host_rvalid after release.
- With ARB_STATS_EN defined, run the third scenario → stat_host_grants = 1, stat_stall_cycles = 1.
